// File: rtl/stack_unit.sv
// Parametrised LIFO stack for the 8-Queen datapath: full/empty flags, sticky
// overflow/underflow errors, push+pop replace-top, synchronous clear and a peek port.
module stack_unit #(
  parameter int DEPTH = 8,
  parameter int SIZE  = 6,
  parameter int CW    = $clog2(DEPTH + 1),
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [SIZE-1:0] bus_in,
  input  logic [IW-1:0]   peek_index,
  output logic [SIZE-1:0] bus_out,
  output logic [SIZE-1:0] peek_out,
  output logic            peek_valid,
  output logic [CW-1:0]   count,
  output logic            empty,
  output logic            full,
  output logic            overflow,
  output logic            underflow
);

  // Common width able to hold DEPTH, any count and any peek index.
  localparam int PW = IW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [SIZE-1:0] mem_q [DEPTH];
  logic [SIZE-1:0] mem_d [DEPTH];
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;

  logic            empty_w, full_w;
  logic [IW-1:0]   top_idx;
  logic [IW-1:0]   push_idx;
  logic [PW-1:0]   peek_ext;
  logic [PW-1:0]   count_ext;
  logic            peek_in_range;

  assign empty_w  = (count_q == '0);
  assign full_w   = (count_q == DEPTH_C);
  // Only used when !empty / !full respectively, so both always fit in IW bits.
  assign top_idx  = IW'(count_q - CW'(1));
  assign push_idx = IW'(count_q);

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (full_w) begin
            ovf_d = 1'b1;
          end else begin
            mem_d[push_idx] = bus_in;
            count_d         = count_q + CW'(1);
          end
        end
        2'b01: begin
          // Popped contents stay in storage so peek can still see them.
          if (empty_w) udf_d = 1'b1;
          else         count_d = count_q - CW'(1);
        end
        2'b11: begin
          if (empty_w) begin
            mem_d[0] = bus_in;
            count_d  = CW'(1);
            udf_d    = 1'b1;
          end else begin
            mem_d[top_idx] = bus_in;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Peek indices past DEPTH exist only when DEPTH is not a power of two.
  assign peek_ext      = PW'(peek_index);
  assign count_ext     = PW'(count_q);
  assign peek_in_range = (peek_ext < DEPTH_P);

  always_comb begin
    peek_out = '0;
    if (peek_in_range) peek_out = mem_q[peek_index];
  end

  assign peek_valid = (peek_ext < count_ext);
  assign bus_out    = empty_w ? '0 : mem_q[top_idx];
  assign count      = count_q;
  assign empty      = empty_w;
  assign full       = full_w;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed self-checking bench for stack_unit at DEPTH=8, SIZE=6.
module tb_stack_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       clear = 1'b0;
  logic [5:0] bus_in = '0;
  logic [2:0] peek_index = '0;
  logic [5:0] bus_out;
  logic [5:0] peek_out;
  logic       peek_valid;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       underflow;

  int passed = 0;
  int total  = 0;

  stack_unit #(.DEPTH(8), .SIZE(6)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .clear(clear),
    .bus_in(bus_in), .peek_index(peek_index), .bus_out(bus_out),
    .peek_out(peek_out), .peek_valid(peek_valid), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Apply one cycle of strobes, then sample 1 time unit after the edge.
  task automatic cycle(input logic p, input logic q, input logic c, input logic r,
                       input logic [5:0] d);
    push = p; pop = q; clear = c; reset = r; bus_in = d;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clear = 1'b0; reset = 1'b0; bus_in = '0;
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 1, 6'd0);
    peek_index = 3'd0; #1;
    total++; if (bus_out !== 6'd0) $display("FAIL reset_bus_out got=%0d exp=0", bus_out); else passed++;
    total++; if (count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", count); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL reset_empty got=%0b exp=1", empty); else passed++;
    total++; if (full !== 1'b0) $display("FAIL reset_full got=%0b exp=0", full); else passed++;
    total++; if ({overflow, underflow} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {overflow, underflow}); else passed++;
    total++; if (peek_valid !== 1'b0) $display("FAIL reset_peek_valid got=%0b exp=0", peek_valid); else passed++;
    total++; if (peek_out !== 6'd0) $display("FAIL reset_peek_out got=%0d exp=0", peek_out); else passed++;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      cycle(1, 0, 0, 0, 6'(i));
      total++; if (bus_out !== 6'(i)) $display("FAIL fill_bus_out i=%0d got=%0d exp=%0d", i, bus_out, i); else passed++;
      total++; if (count !== 4'(i)) $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i); else passed++;
    end
    total++; if ({full, empty, overflow} !== 3'b100) $display("FAIL fill_flags got=%b exp=100", {full, empty, overflow}); else passed++;
    peek_index = 3'd7; #1;
    total++; if (peek_valid !== 1'b1 || peek_out !== 6'd8) $display("FAIL fill_peek7 got=%0b/%0d exp=1/8", peek_valid, peek_out); else passed++;
  endtask

  task automatic test_overflow_pop();
    cycle(1, 0, 0, 0, 6'd9);
    total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got=%0b exp=1", overflow); else passed++;
    total++; if (count !== 4'd8) $display("FAIL ovf_count got=%0d exp=8", count); else passed++;
    total++; if (bus_out !== 6'd8) $display("FAIL ovf_bus_out got=%0d exp=8", bus_out); else passed++;
    for (int k = 1; k <= 8; k++) begin
      cycle(0, 1, 0, 0, 6'd0);
      total++; if (bus_out !== 6'(8 - k)) $display("FAIL pop_bus_out k=%0d got=%0d exp=%0d", k, bus_out, 8 - k); else passed++;
      total++; if (count !== 4'(8 - k)) $display("FAIL pop_count k=%0d got=%0d exp=%0d", k, count, 8 - k); else passed++;
    end
    total++; if ({empty, overflow, underflow} !== 3'b110) $display("FAIL pop_end_flags got=%b exp=110", {empty, overflow, underflow}); else passed++;
  endtask

  task automatic test_underflow();
    cycle(0, 1, 0, 0, 6'd0);
    total++; if (underflow !== 1'b1) $display("FAIL udf_flag got=%0b exp=1", underflow); else passed++;
    total++; if (count !== 4'd0) $display("FAIL udf_count got=%0d exp=0", count); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL udf_ovf_sticky got=%0b exp=1", overflow); else passed++;
  endtask

  task automatic test_replace_empty();
    cycle(0, 0, 1, 0, 6'd0);
    total++; if ({overflow, underflow} !== 2'b00) $display("FAIL clr_flags got=%b exp=00", {overflow, underflow}); else passed++;
    cycle(1, 1, 0, 0, 6'd5);
    total++; if (count !== 4'd1) $display("FAIL repl_empty_count got=%0d exp=1", count); else passed++;
    total++; if (bus_out !== 6'd5) $display("FAIL repl_empty_bus_out got=%0d exp=5", bus_out); else passed++;
    total++; if (underflow !== 1'b1) $display("FAIL repl_empty_udf got=%0b exp=1", underflow); else passed++;
  endtask

  task automatic test_replace();
    cycle(0, 0, 1, 0, 6'd0);
    cycle(1, 0, 0, 0, 6'd3);
    cycle(1, 0, 0, 0, 6'd4);
    cycle(1, 1, 0, 0, 6'd9);
    total++; if (count !== 4'd2) $display("FAIL repl_count got=%0d exp=2", count); else passed++;
    total++; if (bus_out !== 6'd9) $display("FAIL repl_bus_out got=%0d exp=9", bus_out); else passed++;
    total++; if (underflow !== 1'b0) $display("FAIL repl_udf got=%0b exp=0", underflow); else passed++;
    peek_index = 3'd0; #1;
    total++; if (peek_out !== 6'd3 || peek_valid !== 1'b1) $display("FAIL repl_peek0 got=%0d/%0b exp=3/1", peek_out, peek_valid); else passed++;
    peek_index = 3'd1; #1;
    total++; if (peek_out !== 6'd9 || peek_valid !== 1'b1) $display("FAIL repl_peek1 got=%0d/%0b exp=9/1", peek_out, peek_valid); else passed++;
    peek_index = 3'd2; #1;
    total++; if (peek_valid !== 1'b0) $display("FAIL repl_peek2_valid got=%0b exp=0", peek_valid); else passed++;
  endtask

  task automatic test_replace_full();
    cycle(0, 0, 1, 0, 6'd0);
    for (int i = 1; i <= 8; i++) cycle(1, 0, 0, 0, 6'(i + 10));
    cycle(1, 1, 0, 0, 6'd33);
    total++; if (count !== 4'd8 || bus_out !== 6'd33) $display("FAIL repl_full got=%0d/%0d exp=8/33", count, bus_out); else passed++;
    total++; if ({full, overflow, underflow} !== 3'b100) $display("FAIL repl_full_flags got=%b exp=100", {full, overflow, underflow}); else passed++;
    peek_index = 3'd6; #1;
    total++; if (peek_out !== 6'd17) $display("FAIL repl_full_peek6 got=%0d exp=17", peek_out); else passed++;
  endtask

  task automatic test_clear();
    cycle(0, 0, 1, 0, 6'd0);
    cycle(1, 0, 0, 0, 6'd10);
    cycle(1, 0, 0, 0, 6'd20);
    cycle(1, 0, 0, 0, 6'd30);
    cycle(0, 1, 0, 0, 6'd0);
    cycle(0, 1, 0, 0, 6'd0);
    cycle(0, 1, 0, 0, 6'd0);
    cycle(0, 1, 0, 0, 6'd0);
    total++; if (underflow !== 1'b1) $display("FAIL pre_clear_udf got=%0b exp=1", underflow); else passed++;
    cycle(1, 0, 1, 0, 6'd40);
    total++; if (count !== 4'd0 || empty !== 1'b1) $display("FAIL clear_count got=%0d/%0b exp=0/1", count, empty); else passed++;
    total++; if ({overflow, underflow} !== 2'b00) $display("FAIL clear_flags got=%b exp=00", {overflow, underflow}); else passed++;
    total++; if (bus_out !== 6'd0) $display("FAIL clear_bus_out got=%0d exp=0", bus_out); else passed++;
    peek_index = 3'd1; #1;
    total++; if (peek_out !== 6'd20 || peek_valid !== 1'b0) $display("FAIL clear_peek1 got=%0d/%0b exp=20/0", peek_out, peek_valid); else passed++;
    peek_index = 3'd0; #1;
    total++; if (peek_out !== 6'd10) $display("FAIL clear_push_ignored got=%0d exp=10", peek_out); else passed++;
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, 0, 0, 6'd10);
    cycle(1, 0, 0, 0, 6'd20);
    cycle(1, 0, 0, 0, 6'd30);
    total++; if (count !== 4'd3 || bus_out !== 6'd30) $display("FAIL pre_reset got=%0d/%0d exp=3/30", count, bus_out); else passed++;
    cycle(1, 0, 0, 1, 6'd50);
    total++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) $display("FAIL rst_mid_count got=%0d/%0b/%0b exp=0/1/0", count, empty, full); else passed++;
    total++; if (bus_out !== 6'd0 || {overflow, underflow} !== 2'b00) $display("FAIL rst_mid_out got=%0d/%b exp=0/00", bus_out, {overflow, underflow}); else passed++;
    for (int i = 0; i < 8; i++) begin
      peek_index = 3'(i); #1;
      total++; if (peek_out !== 6'd0 || peek_valid !== 1'b0) $display("FAIL rst_mid_peek i=%0d got=%0d/%0b exp=0/0", i, peek_out, peek_valid); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow_pop();
    test_underflow();
    test_replace_empty();
    test_replace();
    test_replace_full();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
# stack_unit

Parametrised LIFO stack for the 8-Queen datapath, and the successor to the fixed-depth stack datapath. It adds full/empty flags, an exposed occupancy count, and sticky overflow/underflow errors. It also adds a push+pop "replace top" operation, a synchronous clear, and a random-access peek port. The peek port lets the placement checker read every stored queen without popping. It sits between the solver controller, which drives the push/pop/clear strobes, and the shared data bus.

## Interface
Parameters:
- DEPTH, 8: number of entries; legal range ≥ 2, need not be a power of two.
- SIZE, 6: entry width in bits.
- Derived: CW = $clog2(DEPTH+1) (count width); IW = $clog2(DEPTH) (index width).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; highest priority.
- push  input  1  write bus_in on top of the stack.
- pop  input  1  remove the top entry.
- clear  input  1  synchronous empty; priority over push/pop.
- bus_in  input  SIZE  data to push or replace.
- peek_index  input  IW  entry address, 0 = bottom.
- bus_out  output  SIZE  current top entry (combinational from registers).
- peek_out  output  SIZE  entry at peek_index (combinational).
- peek_valid  output  1  peek_index < count.
- count  output  CW  number of valid entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: a push was refused.
- underflow  output  1  sticky: a pop was refused.

## Operation
- Storage is DEPTH registers of SIZE bits plus a CW-bit count register and two sticky flag registers.
- Priority on each edge: reset > clear > push/pop decode.
- reset: all storage = 0, count = 0, overflow = underflow = 0.
- clear: count = 0, both flags = 0. Storage is untouched.
- Decode of {push,pop} when not in reset or clear:
  - 00: hold.
  - 10, not full: mem[count] ← bus_in, count+1.
  - 10, full: no storage/count change, overflow ← 1.
  - 01, not empty: count−1. The popped entry's contents are retained, not zeroed.
  - 01, empty: no change, underflow ← 1.
  - 11, not empty: replace top. mem[count−1] ← bus_in, count unchanged, no flag. This holds when full too.
  - 11, empty: acts as a push (mem[0] ← bus_in, count = 1) and underflow ← 1.
- bus_out = mem[count−1] when !empty, else all-zero.
- peek_out = mem[peek_index] regardless of count; peek_valid qualifies it.
- peek_index ≥ DEPTH (non-power-of-two DEPTH): peek_out = 0, peek_valid = 0.
- Flags stay set until reset or clear; later legal operations do not clear them.
- Arithmetic is unsigned; count never wraps. The full/empty guards make count ∈ [0, DEPTH].

## Timing
- Read latency is zero: bus_out, peek_out, peek_valid, empty, full and count are combinational from registered state.
- Each therefore reflects an operation in the cycle after the edge that applied it.
- Push at edge n: bus_out = pushed value and count+1 are visible from edge n until the next edge.
- Pop at edge n: the new top is visible after edge n. No pop-then-read cycle is needed.
- One operation per cycle, sustainable back-to-back indefinitely; no stall or handshake.
- Inputs are sampled only at the rising edge; strobes are level-sensitive per cycle, not edge-detected.
- Reset or clear asserted mid-sequence takes effect at that edge. A push/pop in the same cycle is discarded.
- Reset values: bus_out = 0, peek_out = 0, peek_valid = 0, count = 0, empty = 1, full = 0, overflow = 0, underflow = 0.

## Test plan
All scenarios use DEPTH=8, SIZE=6.
- Reset then push 1..8 on consecutive cycles:
  - bus_out tracks 1,2,…,8.
  - count ends at 8, full = 1, empty = 0, overflow = 0.
- From full, push 9 then pop 8 times:
  - The push is refused: overflow = 1, count stays 8, bus_out = 8.
  - The pops give bus_out 7,6,…,1, then 0 with empty = 1. overflow stays 1.
- From empty, pop:
  - underflow = 1, count = 0.
- From empty, then push&pop with bus_in = 5:
  - count = 1, bus_out = 5, underflow = 1.
- Push 3,4 then push&pop with bus_in = 9:
  - count = 2, bus_out = 9, peek_index = 0 gives 3.
  - peek_index = 2 gives peek_valid = 0.
- Push 10,20,30 then assert clear together with push:
  - count = 0, empty = 1, flags = 0, the push is ignored.
  - Storage is retained: peek_index = 1 gives peek_out = 20, peek_valid = 0.
- Push 10,20,30 then assert reset together with push:
  - All reset values apply and peek_out = 0 for every index.
